// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory controller with a fixed, parameterised access latency.
// One request in flight at a time; completion signalled by a one-cycle mem_rdy pulse.
module data_mem_ctrl #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_enable,
    input  logic        wr_enable,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_data,
    output logic [31:0] mem_data,
    output logic        mem_rdy,
    output logic        busy,
    output logic        addr_err
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [31:0] DEPTH_W  = 32'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic        accept;
    logic        enter_done;
    logic        in_range_d;
    logic        in_range_q;
    logic [31:0] ram_rdata;
    logic [31:0] mem_data_q;

    logic [31:0] ram [DEPTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rd_enable || wr_enable) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
                if (cnt_q <= 4'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request as it will be latched; lets a LATENCY=1 read use it the same edge.
    always_comb begin
        addr_d = accept ? cpu_addr  : addr_q;
        data_d = accept ? cpu_data  : data_q;
        wr_d   = accept ? wr_enable : wr_q;
    end

    assign enter_done = (state_d == S_DONE) && (state_q != S_DONE);
    assign in_range_d = addr_d < DEPTH_W;
    assign in_range_q = addr_q < DEPTH_W;
    assign ram_rdata  = ram[addr_d[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            wr_q       <= 1'b0;
            mem_data_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            if (enter_done && !wr_d) begin
                mem_data_q <= in_range_d ? ram_rdata : 32'd0;
            end
        end
    end

    // Commit happens on the edge leaving DONE, so a reset beforehand aborts it.
    always_ff @(posedge clk) begin
        if (state_q == S_DONE && wr_q && in_range_q) begin
            ram[addr_q[AW-1:0]] <= data_q;
        end
    end

    assign mem_data = mem_data_q;
    assign mem_rdy  = (state_q == S_DONE);
    assign busy     = (state_q != S_IDLE);
    assign addr_err = mem_rdy && !in_range_q;

endmodule
